store_aligner: RTL
==================

Name: store_aligner

Overview:
- Memory-stage store engine; the write-side counterpart of the writeback load-merge logic.
- Accepts one store (opcode, byte address, data) per handshake and emits word-aligned memory write beats with byte enables.
- Misaligned word/half stores are split into two consecutive aligned beats, so memory only ever sees aligned words.

Parameters:
- ADDR_W, 32, byte-address width; wrap is modulo 2^ADDR_W.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- halt  input  1  pipeline freeze; when 1, all state and outputs hold
- in_valid  input  1  store request present
- in_ready  output  1  block can accept a request
- opcode  input  5  3..5 word, 6..8 halfword, 9..11 byte; other values are not stores
- addr  input  ADDR_W  byte address of the store
- data  input  32  store data, right-justified (byte/half in low bits)
- mem_req  output  1  write beat valid
- mem_ready  input  1  memory accepts the current beat
- mem_addr  output  ADDR_W  word-aligned beat address (low 2 bits always 0)
- mem_wdata  output  32  lane-shifted write data
- mem_be  output  4  byte enables; bit i = byte lane i (little-endian)
- store_done  output  1  one-cycle pulse after the last beat of a store is accepted
- misaligned  output  1  high while the current store is a two-beat split

Behaviour:
- Reset (rst_n=0, async) values:
  - state=IDLE; in_ready=1; mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; store_done=0; misaligned=0.
- Reset asserted mid-store abandons it; no further beats are issued.
- States:
  - IDLE: in_ready=1.
  - BEAT0: first or only beat outstanding.
  - BEAT1: second beat of a split outstanding.
  - in_ready=0 in BEAT0 and BEAT1.
- Accept: posedge with in_valid=1, in_ready=1, halt=0.
  - If opcode is not in 3..11: request dropped; stay in IDLE; no beat; no done pulse.
  - Otherwise: go to BEAT0, and mem_req=1 on the next cycle (1-cycle latency).
- Decode:
  - off = addr[1:0].
  - mask = 4'b1111 (word), 4'b0011 (half), 4'b0001 (byte).
  - split = (word and off!=0) or (half and off==3). A byte store never splits.
- Beat 0 (registered at accept):
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - mem_wdata = data << 8*off.
  - mem_be = (mask << off)[3:0].
  - misaligned = split.
- Beat 1 (registered when beat 0 is accepted with split=1):
  - mem_addr = beat0 addr + 4, wrapping modulo 2^ADDR_W.
  - mem_wdata = data >> 8*(4-off).
  - mem_be = mask >> (4-off).
- Beat handshake:
  - A beat completes on a posedge with mem_req=1, mem_ready=1, halt=0.
  - mem_addr, mem_wdata and mem_be are stable while mem_req=1 and mem_ready=0.
- Transitions:
  - BEAT0 → BEAT1 if split, else → IDLE.
  - BEAT1 → IDLE.
  - On → IDLE: mem_req=0, mem_be=0, store_done=1 for exactly one cycle, misaligned=0.
- Back-to-back: in_ready rises in the cycle after the final beat completes; the next store can be accepted on that edge. Peak rate is 1 store per 2 cycles.
- halt=1: no transitions, no accept, outputs hold. A store_done pulse that is high stays high until halt drops.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Word store, addr=0x100, data=0xAABBCCDD, mem_ready tied 1 → one beat: addr 0x100, wdata 0xAABBCCDD, be 4'b1111; store_done pulses once, 2 cycles after accept.
- Half store, addr=0x102, data=0x00001234 → one beat: addr 0x100, wdata 0x12340000, be 4'b1100, misaligned=0.
- Word store, addr=0x101, data=0xAABBCCDD → beat 0: addr 0x100, wdata 0xBBCCDD00, be 4'b1110. Beat 1: addr 0x104, wdata 0x000000AA, be 4'b0001. misaligned=1 across both beats.
- Half store, addr=0xFFFFFFFF, data=0x5678 → beat 0: addr 0xFFFFFFFC, be 4'b1000, wdata 0x78000000. Beat 1: addr 0x00000000, be 4'b0001, wdata 0x00000056.
- mem_ready held 0 for 3 cycles during beat 0, with halt pulsed once → beat 0 outputs unchanged throughout, in_ready stays 0, no store_done until acceptance.
- rst_n dropped while in BEAT1 → mem_req=0 and in_ready=1 immediately (async); after release, byte store to addr=0x203 with data 0xEE → addr 0x200, wdata 0xEE000000, be 4'b1000.

Source files
------------

// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - store engine splitting byte/half/word stores into aligned write beats
// Misaligned stores that cross a word boundary are issued as two consecutive beats.
module store_aligner #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              halt,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              store_done,
   output logic              misaligned
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t      state;
   logic [31:0] data_q;
   logic [1:0]  off_q;
   logic [3:0]  mask_q;

   logic        is_word, is_half, is_byte, is_store, split;
   logic [1:0]  off;
   logic [3:0]  mask, be0, be1;
   logic [2:0]  rshift;
   logic [31:0] wdata0, wdata1;

   assign off      = addr[1:0];
   assign is_word  = (opcode >= 5'd3) && (opcode <= 5'd5);
   assign is_half  = (opcode >= 5'd6) && (opcode <= 5'd8);
   assign is_byte  = (opcode >= 5'd9) && (opcode <= 5'd11);
   assign is_store = is_word || is_half || is_byte;
   assign mask     = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001);
   assign split    = (is_word && off != 2'd0) || (is_half && off == 2'd3);
   assign be0      = mask << off;
   assign wdata0   = data << {off, 3'b000};

   // Second beat carries the bytes that spilled past lane 3 of the first word.
   assign rshift   = 3'd4 - {1'b0, off_q};
   assign be1      = mask_q >> rshift;
   assign wdata1   = data_q >> {rshift, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         store_done <= 1'b0;
         misaligned <= 1'b0;
         data_q     <= '0;
         off_q      <= '0;
         mask_q     <= '0;
      end else if (!halt) begin
         store_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && is_store) begin
                  state      <= BEAT0;
                  in_ready   <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata  <= wdata0;
                  mem_be     <= be0;
                  misaligned <= split;
                  data_q     <= data;
                  off_q      <= off;
                  mask_q     <= mask;
               end
            end
            BEAT0, BEAT1: begin
               if (mem_ready) begin
                  if (state == BEAT0 && misaligned) begin
                     state     <= BEAT1;
                     mem_addr  <= mem_addr + ADDR_W'(4);
                     mem_wdata <= wdata1;
                     mem_be    <= be1;
                  end else begin
                     state      <= IDLE;
                     in_ready   <= 1'b1;
                     mem_req    <= 1'b0;
                     mem_be     <= 4'b0000;
                     store_done <= 1'b1;
                     misaligned <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
